mem_ctrl: RTL and testbench

Memory controller between the `riscv` core and the single byte-wide unified RAM. It arbitrates instruction fetches from `pc_reg` against load/store requests from `mem`, and serialises each request into byte cycles on the RAM port. It assembles little-endian words and raises the stall request that `ctrl` consumes as `req_if`.

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_ctrl_if.sv | 39 +++
 rtl/mem_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial unified memory controller.
package mem_ctrl_pkg;

  localparam int RAM_AW_DEF = 17;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_t;

  // Byte count for a size code; the unused code 11 behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Core-side request/response signals plus the byte-wide RAM port of mem_ctrl.
interface mem_ctrl_if #(
  parameter int RAM_AW = mem_ctrl_pkg::RAM_AW_DEF
);

  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_data;
  logic              if_done;

  logic              re;
  logic [31:0]       raddr;
  logic [1:0]        rsize;
  logic [31:0]       rdata;

  logic              we;
  logic [31:0]       waddr;
  logic [1:0]        wsize;
  logic [31:0]       wdata;

  logic              mem_done;
  logic              stall_req;

  logic [RAM_AW-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;

  modport slave (
    input  if_req, if_addr, re, raddr, rsize, we, waddr, wsize, wdata, ram_dout,
    output if_data, if_done, rdata, mem_done, stall_req, ram_addr, ram_wr, ram_din
  );

  modport master (
    output if_req, if_addr, re, raddr, rsize, we, waddr, wsize, wdata, ram_dout,
    input  if_data, if_done, rdata, mem_done, stall_req, ram_addr, ram_wr, ram_din
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetch vs load/store onto a single byte-wide RAM, one byte per cycle,
// assembling little-endian words and producing the pipeline stall request.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEF
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  state_t            state_reg, state_next;
  op_t               op_reg, op_next;
  logic [RAM_AW-1:0] base_reg, base_next;
  logic [2:0]        n_reg, n_next;
  logic [1:0]        i_reg, i_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [31:0]       asm_reg, asm_next;
  logic [31:0]       wbuf_reg, wbuf_next;
  logic [31:0]       if_data_reg, if_data_next;
  logic [31:0]       rdata_reg, rdata_next;

  logic [1:0]        last_idx;
  logic              cap_en;
  logic [1:0]        cap_lane;

  assign last_idx = 2'(n_reg - 3'd1);

  // RAM data trails its address by one cycle, so the byte landing on the edge
  // that ends cycle cnt belongs to lane cnt-1.
  assign cap_en   = (state_reg == READ) && (cnt_reg != 3'd0);
  assign cap_lane = 2'(cnt_reg - 3'd1);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign asm_next[8*gi +: 8] =
          (state_reg == IDLE)                ? 8'h00        :
          (cap_en && (cap_lane == 2'(gi)))   ? bus.ram_dout :
                                               asm_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      op_reg      <= OP_FETCH;
      base_reg    <= '0;
      n_reg       <= 3'd4;
      i_reg       <= 2'd0;
      cnt_reg     <= 3'd0;
      asm_reg     <= 32'h0;
      wbuf_reg    <= 32'h0;
      if_data_reg <= 32'h0;
      rdata_reg   <= 32'h0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      base_reg    <= base_next;
      n_reg       <= n_next;
      i_reg       <= i_next;
      cnt_reg     <= cnt_next;
      asm_reg     <= asm_next;
      wbuf_reg    <= wbuf_next;
      if_data_reg <= if_data_next;
      rdata_reg   <= rdata_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    base_next    = base_reg;
    n_next       = n_reg;
    i_next       = i_reg;
    cnt_next     = cnt_reg;
    wbuf_next    = wbuf_reg;
    if_data_next = if_data_reg;
    rdata_next   = rdata_reg;

    case (state_reg)
      IDLE: begin
        i_next   = 2'd0;
        cnt_next = 3'd0;
        if (bus.we) begin
          state_next = WRITE;
          op_next    = OP_STORE;
          base_next  = bus.waddr[RAM_AW-1:0];
          n_next     = size_bytes(bus.wsize);
          wbuf_next  = bus.wdata;
        end else if (bus.re) begin
          state_next = READ;
          op_next    = OP_LOAD;
          base_next  = bus.raddr[RAM_AW-1:0];
          n_next     = size_bytes(bus.rsize);
        end else if (bus.if_req) begin
          state_next = READ;
          op_next    = OP_FETCH;
          base_next  = bus.if_addr[RAM_AW-1:0];
          n_next     = 3'd4;
        end
      end

      READ: begin
        cnt_next = cnt_reg + 3'd1;
        if (i_reg != last_idx) begin
          i_next = i_reg + 2'd1;
        end
        if (cnt_reg == n_reg) begin
          state_next = DONE;
          if (op_reg == OP_FETCH) begin
            if_data_next = asm_next;
          end else begin
            rdata_next = asm_next;
          end
        end
      end

      WRITE: begin
        if (i_reg == last_idx) begin
          state_next = DONE;
        end else begin
          i_next = i_reg + 2'd1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.ram_addr  = base_reg + RAM_AW'(i_reg);
  assign bus.ram_wr    = (state_reg == WRITE);
  assign bus.ram_din   = (state_reg == WRITE) ? wbuf_reg[{i_reg, 3'b000} +: 8] : 8'h00;
  assign bus.if_done   = (state_reg == DONE) && (op_reg == OP_FETCH);
  assign bus.mem_done  = (state_reg == DONE) && (op_reg != OP_FETCH);
  assign bus.if_data   = if_data_reg;
  assign bus.rdata     = rdata_reg;
  // Dropping stall during DONE lets the pipeline advance on the edge that ends it.
  assign bus.stall_req = (bus.if_req | bus.re | bus.we) & (state_reg != DONE);

  generate
    if (RAM_AW < 32) begin : g_unused
      logic unused_addr_hi;
      assign unused_addr_hi = ^{bus.if_addr[31:RAM_AW], bus.raddr[31:RAM_AW],
                                bus.waddr[31:RAM_AW]};
    end
  endgenerate

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a registered-read byte RAM model.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_ctrl_if #(.RAM_AW(AW)) bus ();

  mem_ctrl #(.RAM_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]    ram [0:(1<<AW)-1];
  logic [7:0]    ram_q;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [7:0]    bd_data;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (bus.ram_wr) ram[bus.ram_addr] <= bus.ram_din;
    ram_q <= ram[bus.ram_addr];
  end
  assign bus.ram_dout = ram_q;

  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [AW-1:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.re = 1'b0; bus.raddr = 32'h0; bus.rsize = 2'b00;
    bus.we = 1'b0; bus.waddr = 32'h0; bus.wsize = 2'b00; bus.wdata = 32'h0;
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    vectors++;
    if ({bus.ram_wr, bus.ram_addr, bus.ram_din, bus.if_data, bus.rdata,
         bus.if_done, bus.mem_done, bus.stall_req} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got wr=%b addr=%h din=%h ifd=%h rd=%h ifdn=%b mdn=%b st=%b required all zero",
               bus.ram_wr, bus.ram_addr, bus.ram_din, bus.if_data, bus.rdata,
               bus.if_done, bus.mem_done, bus.stall_req);
    end
    bus.if_req = 1'b1;
    #1;
    vectors++;
    if (bus.stall_req !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_stall_follows got %b required 1", bus.stall_req);
    end
    bus.if_req = 1'b0;
    load_byte(17'h00000, 8'h13);
    load_byte(17'h00001, 8'h00);
    load_byte(17'h00002, 8'h00);
    load_byte(17'h00003, 8'h00);
    load_byte(17'h00101, 8'h80);
    load_byte(17'h00102, 8'hFF);
    load_byte(17'h1FFFF, 8'h11);
    vectors++;
    if (bus.if_done !== 1'b0 || bus.ram_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold got if_done=%b ram_wr=%b required 0 0", bus.if_done, bus.ram_wr);
    end
    rst = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_fetch();
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k < 4) begin
        vectors++;
        if (bus.ram_addr !== AW'(k)) begin
          miscompares++;
          $display("FAIL fetch_addr k=%0d got %h required %h", k, bus.ram_addr, AW'(k));
        end
      end
      vectors++;
      if (bus.if_done !== (k == 5)) begin
        miscompares++;
        $display("FAIL fetch_done k=%0d got %b required %b", k, bus.if_done, (k == 5));
      end
      vectors++;
      if (bus.stall_req !== (k != 5)) begin
        miscompares++;
        $display("FAIL fetch_stall k=%0d got %b required %b", k, bus.stall_req, (k != 5));
      end
    end
    vectors++;
    if (bus.if_data !== 32'h00000013) begin
      miscompares++;
      $display("FAIL fetch_data got %h required 00000013", bus.if_data);
    end
    $display("fetch addr=%h data=%h", 32'h0, bus.if_data);
    bus.if_req = 1'b0;
    tick();
    vectors++;
    if (bus.if_done !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_done_once got %b required 0", bus.if_done);
    end
  endtask

  task automatic test_load_half();
    bus.re = 1'b1; bus.rsize = 2'b01; bus.raddr = 32'h101;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k < 3) begin
        vectors++;
        if (bus.ram_addr !== ((k == 0) ? 17'h101 : 17'h102)) begin
          miscompares++;
          $display("FAIL load_addr k=%0d got %h required %h", k, bus.ram_addr,
                   (k == 0) ? 17'h101 : 17'h102);
        end
      end
      vectors++;
      if (bus.mem_done !== (k == 3)) begin
        miscompares++;
        $display("FAIL load_done k=%0d got %b required %b", k, bus.mem_done, (k == 3));
      end
    end
    vectors++;
    if (bus.rdata !== 32'h0000FF80) begin
      miscompares++;
      $display("FAIL load_half_data got %h required 0000ff80", bus.rdata);
    end
    vectors++;
    if (bus.if_data !== 32'h00000013) begin
      miscompares++;
      $display("FAIL if_data_hold got %h required 00000013", bus.if_data);
    end
    $display("load half addr=%h data=%h", 32'h101, bus.rdata);
    bus.re = 1'b0;
    tick();
  endtask

  task automatic test_store_word();
    logic [31:0] wd;
    int lat;
    wd = 32'hDEADBEEF;
    bus.we = 1'b1; bus.wsize = 2'b10; bus.waddr = 32'h200; bus.wdata = wd;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (bus.ram_wr !== (k < 4)) begin
        miscompares++;
        $display("FAIL store_wr k=%0d got %b required %b", k, bus.ram_wr, (k < 4));
      end
      if (k < 4) begin
        vectors++;
        if (bus.ram_addr !== AW'(32'h200 + k) || bus.ram_din !== wd[8*k +: 8]) begin
          miscompares++;
          $display("FAIL store_byte k=%0d got addr=%h din=%h required addr=%h din=%h",
                   k, bus.ram_addr, bus.ram_din, AW'(32'h200 + k), wd[8*k +: 8]);
        end
      end
      vectors++;
      if (bus.mem_done !== (k == 4)) begin
        miscompares++;
        $display("FAIL store_done k=%0d got %b required %b", k, bus.mem_done, (k == 4));
      end
    end
    $display("store word addr=%h data=%h", 32'h200, wd);
    bus.we = 1'b0;
    tick();
    bus.re = 1'b1; bus.rsize = 2'b10; bus.raddr = 32'h200;
    lat = -1;
    for (int k = 0; k < 10 && lat < 0; k++) begin
      tick();
      if (bus.mem_done) lat = k;
    end
    bus.re = 1'b0;
    vectors++;
    if (lat != 5) begin
      miscompares++;
      $display("FAIL readback_latency got %0d required 5", lat);
    end
    vectors++;
    if (bus.rdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL readback_data got %h required deadbeef", bus.rdata);
    end
    $display("load word addr=%h data=%h", 32'h200, bus.rdata);
    tick();
  endtask

  task automatic test_priority();
    int lat;
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    bus.re = 1'b1; bus.rsize = 2'b00; bus.raddr = 32'h102;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 0) begin
        vectors++;
        if (bus.ram_addr !== 17'h102) begin
          miscompares++;
          $display("FAIL prio_load_first got addr %h required 00102", bus.ram_addr);
        end
      end
      vectors++;
      if (bus.mem_done !== (k == 2) || bus.if_done !== 1'b0) begin
        miscompares++;
        $display("FAIL prio_done k=%0d got mem_done=%b if_done=%b required %b 0",
                 k, bus.mem_done, bus.if_done, (k == 2));
      end
    end
    vectors++;
    if (bus.rdata !== 32'h000000FF) begin
      miscompares++;
      $display("FAIL prio_load_data got %h required 000000ff", bus.rdata);
    end
    $display("load byte addr=%h data=%h", 32'h102, bus.rdata);
    bus.re = 1'b0;
    tick();
    vectors++;
    if (bus.stall_req !== 1'b1 || bus.mem_done !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_idle got stall=%b mem_done=%b required 1 0", bus.stall_req, bus.mem_done);
    end
    tick();
    vectors++;
    if (bus.ram_addr !== 17'h0 || bus.ram_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_fetch_start got addr=%h wr=%b required 00000 0", bus.ram_addr, bus.ram_wr);
    end
    lat = -1;
    for (int k = 1; k < 12 && lat < 0; k++) begin
      tick();
      if (bus.if_done) lat = k;
    end
    vectors++;
    if (lat != 5 || bus.if_data !== 32'h00000013) begin
      miscompares++;
      $display("FAIL prio_fetch got latency=%0d data=%h required 5 00000013", lat, bus.if_data);
    end
    $display("fetch addr=%h data=%h", 32'h0, bus.if_data);
    bus.if_req = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_addr [4];
    exp_addr[0] = 17'h1FFFF; exp_addr[1] = 17'h00000;
    exp_addr[2] = 17'h00001; exp_addr[3] = 17'h00002;
    bus.re = 1'b1; bus.rsize = 2'b10; bus.raddr = 32'h1FFFF;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k < 4) begin
        vectors++;
        if (bus.ram_addr !== exp_addr[k]) begin
          miscompares++;
          $display("FAIL wrap_addr k=%0d got %h required %h", k, bus.ram_addr, exp_addr[k]);
        end
      end
      vectors++;
      if (bus.mem_done !== (k == 5)) begin
        miscompares++;
        $display("FAIL wrap_done k=%0d got %b required %b", k, bus.mem_done, (k == 5));
      end
    end
    vectors++;
    if (bus.rdata !== 32'h00001311) begin
      miscompares++;
      $display("FAIL wrap_data got %h required 00001311", bus.rdata);
    end
    $display("load word addr=%h data=%h", 32'h1FFFF, bus.rdata);
    bus.re = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    bus.we = 1'b1; bus.wsize = 2'b10; bus.waddr = 32'h300; bus.wdata = 32'h11223344;
    tick(); tick(); tick();
    vectors++;
    if (bus.ram_addr !== 17'h302 || bus.ram_wr !== 1'b1) begin
      miscompares++;
      $display("FAIL midwr_pre got addr=%h wr=%b required 00302 1", bus.ram_addr, bus.ram_wr);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (bus.ram_wr !== 1'b0 || bus.ram_din !== 8'h00) begin
      miscompares++;
      $display("FAIL midwr_async_drop got wr=%b din=%h required 0 00", bus.ram_wr, bus.ram_din);
    end
    bus.we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (bus.mem_done !== 1'b0) begin
        miscompares++;
        $display("FAIL midwr_no_done_in_reset k=%0d got %b required 0", k, bus.mem_done);
      end
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({bus.ram_wr, bus.ram_addr, bus.ram_din, bus.if_data, bus.rdata,
         bus.if_done, bus.mem_done, bus.stall_req} !== '0) begin
      miscompares++;
      $display("FAIL midwr_after_release got wr=%b addr=%h din=%h ifd=%h rd=%h ifdn=%b mdn=%b st=%b required all zero",
               bus.ram_wr, bus.ram_addr, bus.ram_din, bus.if_data, bus.rdata,
               bus.if_done, bus.mem_done, bus.stall_req);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (bus.mem_done !== 1'b0 || bus.ram_wr !== 1'b0) begin
        miscompares++;
        $display("FAIL midwr_quiet k=%0d got mem_done=%b wr=%b required 0 0", k, bus.mem_done, bus.ram_wr);
      end
    end
    $display("store word addr=%h aborted by reset", 32'h300);
  endtask

  initial begin
    bd_we = 1'b0; bd_addr = '0; bd_data = 8'h00;
    idle_inputs();
    test_reset();
    test_fetch();
    test_load_half();
    test_store_word();
    test_priority();
    test_wrap();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
